// File: rtl/doorlock_ctrl_if.sv
// ============================================================================
// Module      : doorlock_ctrl_if
// Description : Keypad and compare-datapath signal bundle for doorlock_ctrl.
//               DOORLOCK_ALARM_EN adds the alarm output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface doorlock_ctrl_if;
    logic       key_valid;
    logic [3:0] key_val;
    logic       key_enter;
    logic       key_clear;
    logic       door_open_in;
    logic [1:0] lock_state;
    logic [3:0] ps_num;
    logic       door_open;
    logic       locked_out;
    logic [3:0] fail_cnt;
`ifdef DOORLOCK_ALARM_EN
    logic       alarm;

    modport master (
        output key_valid, key_val, key_enter, key_clear, door_open_in,
        input  lock_state, ps_num, door_open, locked_out, fail_cnt, alarm
    );
    modport slave (
        input  key_valid, key_val, key_enter, key_clear, door_open_in,
        output lock_state, ps_num, door_open, locked_out, fail_cnt, alarm
    );
`else
    modport master (
        output key_valid, key_val, key_enter, key_clear, door_open_in,
        input  lock_state, ps_num, door_open, locked_out, fail_cnt
    );
    modport slave (
        input  key_valid, key_val, key_enter, key_clear, door_open_in,
        output lock_state, ps_num, door_open, locked_out, fail_cnt
    );
`endif
endinterface

`default_nettype wire

// File: rtl/doorlock_ctrl.sv
// ============================================================================
// Module      : doorlock_ctrl
// Description : Keypad-entry sequencer with timed open window, failure counter
//               and lockout timer. DOORLOCK_ALARM_EN adds the alarm pulse.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module doorlock_ctrl #(
    parameter int OPEN_CYCLES = 16,
    parameter int MAX_FAIL    = 3,
    parameter int LOCK_CYCLES = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    doorlock_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ENTRY   = 3'd1,
        S_CHECK   = 3'd2,
        S_OPEN    = 3'd3,
        S_LOCKOUT = 3'd4
    } state_t;

    localparam logic [7:0] C_OPEN_LOAD  = 8'(OPEN_CYCLES);
    localparam logic [7:0] C_LOCK_LOAD  = 8'(LOCK_CYCLES);
    localparam logic [3:0] C_MAX_FAIL   = 4'(MAX_FAIL);
    localparam logic [4:0] C_FAIL_LIMIT = 5'(MAX_FAIL);

    state_t     r_state,      w_state;
    logic [1:0] r_lock_state, w_lock_state;
    logic [3:0] r_ps_num,     w_ps_num;
    logic       r_door_open,  w_door_open;
    logic       r_locked_out, w_locked_out;
    logic [3:0] r_fail_cnt,   w_fail_cnt;
    logic [7:0] r_timer,      w_timer;
    logic       r_alarm,      w_alarm;
    logic [4:0] w_fail_inc;

    assign w_fail_inc = {1'b0, r_fail_cnt} + 5'd1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_lock_state <= 2'b00;
            r_ps_num     <= 4'd0;
            r_door_open  <= 1'b0;
            r_locked_out <= 1'b0;
            r_fail_cnt   <= 4'd0;
            r_timer      <= 8'd0;
            r_alarm      <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_lock_state <= w_lock_state;
            r_ps_num     <= w_ps_num;
            r_door_open  <= w_door_open;
            r_locked_out <= w_locked_out;
            r_fail_cnt   <= w_fail_cnt;
            r_timer      <= w_timer;
            r_alarm      <= w_alarm;
        end
    end

    always_comb begin
        w_state      = r_state;
        w_ps_num     = r_ps_num;
        w_door_open  = r_door_open;
        w_locked_out = r_locked_out;
        w_fail_cnt   = r_fail_cnt;
        w_timer      = r_timer;
        w_alarm      = 1'b0;
        w_lock_state = 2'b00;

        case (r_state)
            S_IDLE: begin
                if (bus.key_valid) begin
                    w_ps_num = bus.key_val;
                    w_state  = S_ENTRY;
                end
            end
            S_ENTRY: begin
                if (bus.key_clear) begin
                    w_ps_num = 4'd0;
                    w_state  = S_IDLE;
                end else if (bus.key_enter) begin
                    w_state = S_CHECK;
                end else if (bus.key_valid) begin
                    w_ps_num = bus.key_val;
                end
            end
            S_CHECK: begin
                if (bus.door_open_in) begin
                    w_door_open = 1'b1;
                    w_fail_cnt  = 4'd0;
                    w_timer     = C_OPEN_LOAD;
                    w_state     = S_OPEN;
                end else if (w_fail_inc < C_FAIL_LIMIT) begin
                    w_fail_cnt = w_fail_inc[3:0];
                    w_ps_num   = 4'd0;
                    w_state    = S_IDLE;
                end else begin
                    w_fail_cnt   = C_MAX_FAIL;
                    w_ps_num     = 4'd0;
                    w_locked_out = 1'b1;
                    w_timer      = C_LOCK_LOAD;
                    w_alarm      = 1'b1;
                    w_state      = S_LOCKOUT;
                end
            end
            S_OPEN: begin
                // A vanished verdict relocks just like expiry or a clear.
                if (bus.key_clear || !bus.door_open_in || r_timer <= 8'd1) begin
                    w_door_open = 1'b0;
                    w_ps_num    = 4'd0;
                    w_timer     = 8'd0;
                    w_state     = S_IDLE;
                end else begin
                    w_timer = r_timer - 8'd1;
                end
            end
            S_LOCKOUT: begin
                w_alarm = bus.key_valid | bus.key_enter;
                if (r_timer <= 8'd1) begin
                    w_locked_out = 1'b0;
                    w_fail_cnt   = 4'd0;
                    w_timer      = 8'd0;
                    w_state      = S_IDLE;
                end else begin
                    w_timer = r_timer - 8'd1;
                end
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase

        case (w_state)
            S_ENTRY: w_lock_state = 2'b01;
            S_CHECK: w_lock_state = 2'b10;
            S_OPEN:  w_lock_state = 2'b10;
            default: w_lock_state = 2'b00;
        endcase
    end

    assign bus.lock_state = r_lock_state;
    assign bus.ps_num     = r_ps_num;
    assign bus.door_open  = r_door_open;
    assign bus.locked_out = r_locked_out;
    assign bus.fail_cnt   = r_fail_cnt;

`ifdef DOORLOCK_ALARM_EN
    assign bus.alarm = r_alarm;
`else
    logic w_alarm_unused;
    assign w_alarm_unused = r_alarm;
`endif

endmodule

`default_nettype wire

// File: tb/tb_doorlock_ctrl.sv
// ============================================================================
// Module      : tb_doorlock_ctrl
// Description : Directed-vector bench for doorlock_ctrl with a model of the
//               compare datapath (fixed code 4'hD).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_doorlock_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic dp_kill = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    doorlock_ctrl_if bus ();

    assign bus.door_open_in = (bus.lock_state == 2'b10) && (bus.ps_num == 4'hD) && !dp_kill;

    doorlock_ctrl #(.OPEN_CYCLES(16), .MAX_FAIL(3), .LOCK_CYCLES(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic       kv;
        logic [3:0] val;
        logic       ke;
        logic       kc;
        logic [1:0] e_ls;
        logic [3:0] e_ps;
        logic       e_do;
        logic       e_lo;
        logic [3:0] e_fc;
    } vec_t;

    vec_t tbl [15];

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic [1:0] ls, input logic [3:0] ps,
                           input logic dopen, input logic lo, input logic [3:0] fc);
        chk({tag, ".lock_state"}, {6'd0, bus.lock_state}, {6'd0, ls});
        chk({tag, ".ps_num"},     {4'd0, bus.ps_num},     {4'd0, ps});
        chk({tag, ".door_open"},  {7'd0, bus.door_open},  {7'd0, dopen});
        chk({tag, ".locked_out"}, {7'd0, bus.locked_out}, {7'd0, lo});
        chk({tag, ".fail_cnt"},   {4'd0, bus.fail_cnt},   {4'd0, fc});
    endtask

    task automatic step(input logic kv, input logic [3:0] val, input logic ke, input logic kc);
        bus.key_valid = kv;
        bus.key_val   = val;
        bus.key_enter = ke;
        bus.key_clear = kc;
        @(posedge clk);
        #1;
        bus.key_valid = 1'b0;
        bus.key_val   = 4'h0;
        bus.key_enter = 1'b0;
        bus.key_clear = 1'b0;
    endtask

    task automatic open_door();
        step(1'b1, 4'hD, 1'b0, 1'b0);
        step(1'b0, 4'h0, 1'b1, 1'b0);
        step(1'b0, 4'h0, 1'b0, 1'b0);
        chk_all("open_door", 2'b10, 4'hD, 1'b1, 1'b0, 4'd0);
    endtask

    initial begin
        bus.key_valid = 1'b0;
        bus.key_val   = 4'h0;
        bus.key_enter = 1'b0;
        bus.key_clear = 1'b0;

        step(1'b0, 4'h0, 1'b0, 1'b0);
        step(1'b1, 4'hD, 1'b0, 1'b0);
        chk_all("reset", 2'b00, 4'h0, 1'b0, 1'b0, 4'd0);
        rst_n = 1'b1;

        // Happy path: latency and full open window
        step(1'b1, 4'hD, 1'b0, 1'b0);
        chk_all("ok.entry", 2'b01, 4'hD, 1'b0, 1'b0, 4'd0);
        step(1'b0, 4'h0, 1'b1, 1'b0);
        chk_all("ok.check", 2'b10, 4'hD, 1'b0, 1'b0, 4'd0);
        step(1'b0, 4'h0, 1'b0, 1'b0);
        chk_all("ok.open", 2'b10, 4'hD, 1'b1, 1'b0, 4'd0);
        for (int i = 1; i < 16; i++) begin
            step(1'b0, 4'h0, 1'b0, 1'b0);
            chk($sformatf("ok.hold%0d", i), {7'd0, bus.door_open}, 8'd1);
        end
        step(1'b0, 4'h0, 1'b0, 1'b0);
        chk_all("ok.close", 2'b00, 4'h0, 1'b0, 1'b0, 4'd0);

        //          kv    val   ke    kc    ls     ps    do    lo    fc
        tbl[0]  = '{1'b0, 4'h0, 1'b1, 1'b0, 2'b00, 4'h0, 1'b0, 1'b0, 4'd0};
        tbl[1]  = '{1'b0, 4'h0, 1'b0, 1'b1, 2'b00, 4'h0, 1'b0, 1'b0, 4'd0};
        tbl[2]  = '{1'b1, 4'h5, 1'b0, 1'b0, 2'b01, 4'h5, 1'b0, 1'b0, 4'd0};
        tbl[3]  = '{1'b1, 4'hD, 1'b0, 1'b0, 2'b01, 4'hD, 1'b0, 1'b0, 4'd0};
        tbl[4]  = '{1'b1, 4'h7, 1'b1, 1'b1, 2'b00, 4'h0, 1'b0, 1'b0, 4'd0};
        tbl[5]  = '{1'b1, 4'h3, 1'b0, 1'b0, 2'b01, 4'h3, 1'b0, 1'b0, 4'd0};
        tbl[6]  = '{1'b1, 4'hD, 1'b1, 1'b0, 2'b10, 4'h3, 1'b0, 1'b0, 4'd0};
        tbl[7]  = '{1'b0, 4'h0, 1'b0, 1'b0, 2'b00, 4'h0, 1'b0, 1'b0, 4'd1};
        tbl[8]  = '{1'b1, 4'h3, 1'b0, 1'b0, 2'b01, 4'h3, 1'b0, 1'b0, 4'd1};
        tbl[9]  = '{1'b0, 4'h0, 1'b1, 1'b0, 2'b10, 4'h3, 1'b0, 1'b0, 4'd1};
        tbl[10] = '{1'b0, 4'h0, 1'b0, 1'b0, 2'b00, 4'h0, 1'b0, 1'b0, 4'd2};
        tbl[11] = '{1'b1, 4'hD, 1'b0, 1'b0, 2'b01, 4'hD, 1'b0, 1'b0, 4'd2};
        tbl[12] = '{1'b0, 4'h0, 1'b1, 1'b0, 2'b10, 4'hD, 1'b0, 1'b0, 4'd2};
        tbl[13] = '{1'b0, 4'h0, 1'b0, 1'b0, 2'b10, 4'hD, 1'b1, 1'b0, 4'd0};
        tbl[14] = '{1'b0, 4'h0, 1'b0, 1'b1, 2'b00, 4'h0, 1'b0, 1'b0, 4'd0};
        for (int v = 0; v < 15; v++) begin
            step(tbl[v].kv, tbl[v].val, tbl[v].ke, tbl[v].kc);
            chk_all($sformatf("vec%0d", v), tbl[v].e_ls, tbl[v].e_ps,
                    tbl[v].e_do, tbl[v].e_lo, tbl[v].e_fc);
        end

        // Three wrong codes -> lockout for exactly 32 cycles
        for (int n = 1; n <= 3; n++) begin
            step(1'b1, 4'h3, 1'b0, 1'b0);
            step(1'b0, 4'h0, 1'b1, 1'b0);
`ifdef DOORLOCK_ALARM_EN
            chk($sformatf("alarm.pre%0d", n), {7'd0, bus.alarm}, 8'd0);
`endif
            step(1'b0, 4'h0, 1'b0, 1'b0);
            chk_all($sformatf("fail%0d", n), 2'b00, 4'h0, 1'b0, (n == 3), 4'(n));
        end
`ifdef DOORLOCK_ALARM_EN
        chk("alarm.enter", {7'd0, bus.alarm}, 8'd1);
`endif
        for (int i = 1; i < 32; i++) begin
            step((i % 4) == 0, 4'hD, (i % 4) == 1, (i % 4) == 3);
            chk_all($sformatf("lock%0d", i), 2'b00, 4'h0, 1'b0, 1'b1, 4'd3);
`ifdef DOORLOCK_ALARM_EN
            chk($sformatf("alarm.key%0d", i), {7'd0, bus.alarm}, {7'd0, ((i % 4) < 2)});
`endif
        end
        step(1'b0, 4'h0, 1'b0, 1'b0);
        chk_all("lock.exit", 2'b00, 4'h0, 1'b0, 1'b0, 4'd0);
`ifdef DOORLOCK_ALARM_EN
        chk("alarm.exit", {7'd0, bus.alarm}, 8'd0);
`endif
        step(1'b1, 4'hD, 1'b0, 1'b0);
        chk_all("lock.after", 2'b01, 4'hD, 1'b0, 1'b0, 4'd0);
        step(1'b0, 4'h0, 1'b0, 1'b1);

        // Last digit wins, clear on the fifth open cycle
        step(1'b1, 4'h5, 1'b0, 1'b0);
        open_door();
        for (int i = 2; i <= 4; i++) begin
            step(1'b0, 4'h0, 1'b0, 1'b0);
            chk($sformatf("clr.hold%0d", i), {7'd0, bus.door_open}, 8'd1);
        end
        step(1'b0, 4'h0, 1'b0, 1'b1);
        chk_all("clr.open", 2'b00, 4'h0, 1'b0, 1'b0, 4'd0);

        // Datapath verdict dropping mid-open relocks
        open_door();
        step(1'b0, 4'h0, 1'b0, 1'b0);
        dp_kill = 1'b1;
        step(1'b0, 4'h0, 1'b0, 1'b0);
        dp_kill = 1'b0;
        chk_all("drop", 2'b00, 4'h0, 1'b0, 1'b0, 4'd0);

        // Reset in OPEN
        open_door();
        step(1'b0, 4'h0, 1'b0, 1'b0);
        rst_n = 1'b0;
        step(1'b0, 4'h0, 1'b0, 1'b0);
        chk_all("rst.open", 2'b00, 4'h0, 1'b0, 1'b0, 4'd0);
        rst_n = 1'b1;
        step(1'b1, 4'h9, 1'b0, 1'b0);
        chk_all("rst.after", 2'b01, 4'h9, 1'b0, 1'b0, 4'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
